// File: rtl/mux_out_fifo_bank.sv
// mux_out_fifo_bank
//   Four-lane output buffer that sits directly after the 4-lane MUX stage.
//   Each MUX output lane feeds its own independent FIFO. Every lane has its
//   own pop/valid read port toward the transaction layer. An aggregate pause
//   flag goes back upstream so the MUX/FSM stops pushing before a lane
//   overflows.
//
//   Build option: FIFO_FWFT_EN
//     defined   -> first-word-fall-through read (head word visible combinationally)
//     undefined -> registered read, 1-cycle latency after an accepted pop
//
// Ports
//   clk                  rising-edge clock
//   reset_L              asynchronous, active-low reset
//   push[3:0]            push[i] writes data_in<i> into lane i
//   data_in0..3          lane write words (MUX Out0..Out3)
//   pop[3:0]             pop[i] reads the head of lane i
//   data_out0..3         lane read words
//   valid_out[3:0]       data_out<i> holds a popped (or head) word
//   empty/full[3:0]      lane count == 0 / == DEPTH
//   almost_empty[3:0]    lane count <= AE_THRESH
//   almost_full[3:0]     lane count >= AF_THRESH
//   pause                OR of almost_full, backpressure to MUX/FSM
//   err[3:0]             sticky overflow/underflow per lane
module mux_out_fifo_bank #(
  parameter int DATA_W    = 10,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        push,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        pop,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [3:0]        valid_out,
  output logic [3:0]        empty,
  output logic [3:0]        full,
  output logic [3:0]        almost_empty,
  output logic [3:0]        almost_full,
  output logic              pause,
  output logic [3:0]        err
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] LP_AE    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] w_din  [4];
  logic [DATA_W-1:0] w_dout [4];

  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_din[2] = data_in2;
  assign w_din[3] = data_in3;

  assign data_out0 = w_dout[0];
  assign data_out1 = w_dout[1];
  assign data_out2 = w_dout[2];
  assign data_out3 = w_dout[3];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic              w_empty;
    logic              w_full;
    logic              w_pop_acc;
    logic              w_push_acc;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == LP_DEPTH);
    assign w_pop_acc  = pop[g] && !w_empty;
    // A full lane still takes a push when the head leaves in the same cycle.
    assign w_push_acc = push[g] && (!w_full || w_pop_acc);

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
      if (w_push_acc) begin
        r_mem[r_wr_ptr] <= w_din[g];
      end
    end

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_err    <= 1'b0;
      end else begin
        if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push_acc, w_pop_acc})
          2'b10:   r_count <= r_count + LP_ONE;
          2'b01:   r_count <= r_count - LP_ONE;
          default: r_count <= r_count;
        endcase
        if ((push[g] && !w_push_acc) || (pop[g] && !w_pop_acc)) begin
          r_err <= 1'b1;
        end
      end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented while the lane holds data; forced to zero when
    // empty so the output never exposes unwritten storage.
    assign w_dout[g]    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign valid_out[g] = !w_empty;
`else
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_pop_acc;
        if (w_pop_acc) r_dout <= r_mem[r_rd_ptr];
      end
    end

    assign w_dout[g]    = r_dout;
    assign valid_out[g] = r_valid;
`endif

    assign empty[g]        = w_empty;
    assign full[g]         = w_full;
    assign almost_empty[g] = (r_count <= LP_AE);
    assign almost_full[g]  = (r_count >= LP_AF);
    assign err[g]          = r_err;
  end

  // Flags come from the registered count, so pause rises the cycle after a
  // lane reaches AF_THRESH, leaving DEPTH-AF_THRESH slots for in-flight words.
  assign pause = |almost_full;

endmodule
